// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and flag bit positions for the sequential ALU
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_NOT  = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_ROL  = 4'h8,
        OP_ROR  = 4'h9,
        OP_INC  = 4'hA,
        OP_DEC  = 4'hB,
        OP_PASS = 4'hC,
        OP_CMP  = 4'hD,
        OP_MUL  = 4'hE,
        OP_RSVD = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

    // Bit positions inside the registered flag vector
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;
    localparam int NFLAGS = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - unsigned shift-add multiplier, one partial product per cycle
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;

    // The first partial product is folded into the start cycle so that the
    // full product is ready WIDTH-1 edges after start; cnt_q counts iterations done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            acc_q    <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
            mcand_q  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
            mplier_q <= {1'b0, b[WIDTH-1:1]};
            cnt_q    <= CW'(1);
        end else if (cnt_q != '0 && cnt_q != CW'(WIDTH)) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
            cnt_q    <= cnt_q + CW'(1);
        end else if (done) begin
            cnt_q <= '0;
        end
    end

    assign done    = (cnt_q == CW'(WIDTH));
    assign product = acc_q;

endmodule

// File: rtl/alu_nbit_seq.sv
// rtl/alu_nbit_seq.sv - registered N-bit ALU with valid/ready handshake and sequential multiply
module alu_nbit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   result_q;
    logic [NFLAGS-1:0]  flags_q;

    logic               accept;
    logic               load_alu;
    logic               load_mul;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    logic [WIDTH:0]     add_ext;
    logic [WIDTH:0]     sub_ext;
    logic [WIDTH:0]     inc_ext;
    logic [WIDTH:0]     dec_ext;

    logic [WIDTH-1:0]   alu_res;
    logic [NFLAGS-1:0]  alu_flags;
    logic [WIDTH-1:0]   mul_res;
    logic [NFLAGS-1:0]  mul_flags;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (operand_a),
        .b       (operand_b),
        .done    (mul_done),
        .product (mul_product)
    );

    // Borrow for subtraction shows up as bit WIDTH of the extended difference
    assign add_ext = {1'b0, operand_a} + {1'b0, operand_b};
    assign sub_ext = {1'b0, operand_a} - {1'b0, operand_b};
    assign inc_ext = {1'b0, operand_a} + {{WIDTH{1'b0}}, 1'b1};
    assign dec_ext = {1'b0, operand_a} - {{WIDTH{1'b0}}, 1'b1};

    // Single-cycle datapath: result and carry/overflow per opcode, zero/negative from the result
    always_comb begin
        alu_res   = '0;
        alu_flags = '0;
        case (operation)
            OP_ADD: begin
                alu_res           = add_ext[MSB:0];
                alu_flags[FLAG_C] = add_ext[WIDTH];
                alu_flags[FLAG_V] = (operand_a[MSB] == operand_b[MSB]) && (add_ext[MSB] != operand_a[MSB]);
            end
            OP_SUB: begin
                alu_res           = sub_ext[MSB:0];
                alu_flags[FLAG_C] = sub_ext[WIDTH];
                alu_flags[FLAG_V] = (operand_a[MSB] != operand_b[MSB]) && (sub_ext[MSB] != operand_a[MSB]);
            end
            OP_AND:  alu_res = operand_a & operand_b;
            OP_OR:   alu_res = operand_a | operand_b;
            OP_XOR:  alu_res = operand_a ^ operand_b;
            OP_NOT:  alu_res = ~operand_a;
            OP_SHL: begin
                alu_res           = {operand_a[MSB-1:0], 1'b0};
                alu_flags[FLAG_C] = operand_a[MSB];
            end
            OP_SHR: begin
                alu_res           = {1'b0, operand_a[MSB:1]};
                alu_flags[FLAG_C] = operand_a[0];
            end
            OP_ROL: begin
                alu_res           = {operand_a[MSB-1:0], operand_a[MSB]};
                alu_flags[FLAG_C] = operand_a[MSB];
            end
            OP_ROR: begin
                alu_res           = {operand_a[0], operand_a[MSB:1]};
                alu_flags[FLAG_C] = operand_a[0];
            end
            OP_INC: begin
                alu_res           = inc_ext[MSB:0];
                alu_flags[FLAG_C] = inc_ext[WIDTH];
                alu_flags[FLAG_V] = !operand_a[MSB] && inc_ext[MSB];
            end
            OP_DEC: begin
                alu_res           = dec_ext[MSB:0];
                alu_flags[FLAG_C] = dec_ext[WIDTH];
                alu_flags[FLAG_V] = operand_a[MSB] && !dec_ext[MSB];
            end
            OP_PASS: alu_res = operand_a;
            OP_CMP: begin
                // Compare keeps A visible; only carry/overflow come from A-B
                alu_res           = operand_a;
                alu_flags[FLAG_C] = sub_ext[WIDTH];
                alu_flags[FLAG_V] = (operand_a[MSB] != operand_b[MSB]) && (sub_ext[MSB] != operand_a[MSB]);
            end
            default: alu_res = '0;
        endcase
        alu_flags[FLAG_Z] = (alu_res == '0);
        alu_flags[FLAG_N] = alu_res[MSB];
    end

    // Multiply result: low half, with any set bit in the high half flagged as carry and overflow
    always_comb begin
        mul_res           = mul_product[MSB:0];
        mul_flags         = '0;
        mul_flags[FLAG_C] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_V] = |mul_product[2*WIDTH-1:WIDTH];
        mul_flags[FLAG_Z] = (mul_res == '0);
        mul_flags[FLAG_N] = mul_res[MSB];
    end

    assign accept = in_valid && in_ready;

    // Next-state and load controls; an accept looks the same from IDLE and from a draining HOLD
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        load_alu  = 1'b0;
        load_mul  = 1'b0;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = rst_n;
            ST_HOLD: in_ready = rst_n && out_ready;
            default: in_ready = 1'b0;
        endcase
        case (state_q)
            ST_MUL: begin
                if (mul_done) begin
                    load_mul = 1'b1;
                    state_d  = ST_HOLD;
                end
            end
            default: begin
                if (accept) begin
                    if (operation == OP_MUL) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        load_alu = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end else if (state_q == ST_HOLD && out_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State register and output holding registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_alu) begin
                result_q <= alu_res;
                flags_q  <= alu_flags;
            end else if (load_mul) begin
                result_q <= mul_res;
                flags_q  <= mul_flags;
            end
        end
    end

    assign out_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_MUL);
    assign result    = result_q;
    assign carry_out = flags_q[FLAG_C];
    assign zero      = flags_q[FLAG_Z];
    assign negative  = flags_q[FLAG_N];
    assign overflow  = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_nbit_seq.sv
// tb/tb_alu_nbit_seq.sv - directed self-checking bench for alu_nbit_seq at WIDTH=8
module tb_alu_nbit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
    logic [3:0] operation;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       carry_out;
    logic       zero;
    logic       negative;
    logic       overflow;
    logic       busy;

    int total;
    int bad;

    alu_nbit_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .operation (operation),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flags are compared as {carry, zero, negative, overflow}
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        operation = 4'h0;
        operand_a = 8'h12;
        operand_b = 8'h34;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_in_ready got=%b want=0", in_ready);
        end
        total++;
        if ({out_valid, busy, result, carry_out, zero, negative, overflow} !== 14'h0) begin
            bad++;
            $display("FAIL reset_state got ov=%b busy=%b res=%h flags=%b want all zero",
                     out_valid, busy, result, {carry_out, zero, negative, overflow});
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_in_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_add();
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'h0;
        operand_a = 8'hFF;
        operand_b = 8'h01;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || result !== 8'h00 || {carry_out, zero, negative, overflow} !== 4'b1100) begin
            bad++;
            $display("FAIL add_ff_01 got ov=%b res=%h flags=%b want ov=1 res=00 flags=1100",
                     out_valid, result, {carry_out, zero, negative, overflow});
        end
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL add_drain got ov=%b want=0", out_valid);
        end
    endtask

    // Table of single-cycle ops issued back-to-back with out_ready held high
    task automatic test_alu_ops();
        logic [3:0] t_op  [16];
        logic [7:0] t_a   [16];
        logic [7:0] t_b   [16];
        logic [7:0] t_res [16];
        logic [3:0] t_flg [16];
        t_op = '{4'h1, 4'h1, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'hB,
                 4'hA, 4'hD, 4'hC, 4'hF, 4'h4, 4'hB, 4'h9, 4'h2};
        t_a  = '{8'h80, 8'h10, 8'h50, 8'h0F, 8'h81, 8'h81, 8'h81, 8'h00,
                 8'h7F, 8'h90, 8'h00, 8'h55, 8'h3C, 8'h80, 8'h02, 8'hFF};
        t_b  = '{8'h01, 8'h20, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'hA0, 8'h00, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h0F};
        t_res = '{8'h7F, 8'hF0, 8'h5A, 8'hF0, 8'h02, 8'h40, 8'h03, 8'hFF,
                  8'h80, 8'h90, 8'h00, 8'h00, 8'h00, 8'h7F, 8'h01, 8'h0F};
        t_flg = '{4'b0001, 4'b1010, 4'b0000, 4'b0010, 4'b1000, 4'b1000, 4'b1000, 4'b1010,
                  4'b0011, 4'b1010, 4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0000, 4'b0000};
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            operation = t_op[i];
            operand_a = t_a[i];
            operand_b = t_b[i];
            total++;
            if (in_ready !== 1'b1) begin
                bad++;
                $display("FAIL ops_ready[%0d] got=%b want=1", i, in_ready);
            end
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || result !== t_res[i] ||
                {carry_out, zero, negative, overflow} !== t_flg[i]) begin
                bad++;
                $display("FAIL ops[%0d] op=%h got ov=%b res=%h flags=%b want ov=1 res=%h flags=%b",
                         i, t_op[i], out_valid, result, {carry_out, zero, negative, overflow},
                         t_res[i], t_flg[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] exp_res, input logic [3:0] exp_flg, input string name);
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'hE;
        operand_a = a;
        operand_b = b;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        operand_a = 8'hFF;
        operand_b = 8'hFF;
        operation = 4'h0;
        for (int k = 0; k < 8; k++) begin
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s_busy[%0d] got busy=%b rdy=%b ov=%b want 1 0 0",
                         name, k, busy, in_ready, out_valid);
            end
            if (k == 3) in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || result !== exp_res ||
            {carry_out, zero, negative, overflow} !== exp_flg) begin
            bad++;
            $display("FAIL %s_done got ov=%b busy=%b res=%h flags=%b want ov=1 busy=0 res=%h flags=%b",
                     name, out_valid, busy, result, {carry_out, zero, negative, overflow},
                     exp_res, exp_flg);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        run_mul(8'h10, 8'h20, 8'h00, 4'b1101, "mul_10_20");
        run_mul(8'h0D, 8'h0B, 8'h8F, 4'b0010, "mul_0d_0b");
        run_mul(8'hFF, 8'hFF, 8'h01, 4'b1001, "mul_ff_ff");
    endtask

    task automatic test_hold();
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'h2;
        operand_a = 8'h33;
        operand_b = 8'hCC;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        operation = 4'hC;
        operand_a = 8'hA5;
        for (int k = 0; k < 5; k++) begin
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h00 ||
                {carry_out, zero, negative, overflow} !== 4'b0100) begin
                bad++;
                $display("FAIL hold[%0d] got ov=%b rdy=%b res=%h flags=%b want ov=1 rdy=0 res=00 flags=0100",
                         k, out_valid, in_ready, result, {carry_out, zero, negative, overflow});
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] b_op  [3];
        logic [7:0] b_a   [3];
        logic [7:0] b_res [3];
        logic [3:0] b_flg [3];
        b_op  = '{4'h4, 4'hA, 4'h9};
        b_a   = '{8'hAA, 8'hFF, 8'h01};
        b_res = '{8'hFF, 8'h00, 8'h80};
        b_flg = '{4'b0010, 4'b1100, 4'b1010};
        out_ready = 1'b1;
        operand_b = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            operation = b_op[i];
            operand_a = b_a[i];
            @(posedge clk);
            #1;
            total++;
            if (out_valid !== 1'b1 || result !== b_res[i] ||
                {carry_out, zero, negative, overflow} !== b_flg[i]) begin
                bad++;
                $display("FAIL b2b[%0d] got ov=%b res=%h flags=%b want ov=1 res=%h flags=%b",
                         i, out_valid, result, {carry_out, zero, negative, overflow}, b_res[i], b_flg[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul_reset();
        int seen;
        @(negedge clk);
        in_valid  = 1'b1;
        operation = 4'hC;
        operand_a = 8'h5A;
        out_ready = 1'b1;
        @(negedge clk);
        operation = 4'hE;
        operand_a = 8'h10;
        operand_b = 8'h20;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mrst_busy4 got=%b want=1", busy);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || result !== 8'h00 ||
            {carry_out, zero, negative, overflow} !== 4'b0000) begin
            bad++;
            $display("FAIL mrst_state got ov=%b busy=%b res=%h flags=%b want all zero",
                     out_valid, busy, result, {carry_out, zero, negative, overflow});
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL mrst_no_output got active_cycles=%0d want=0", seen);
        end
        run_mul(8'h03, 8'h05, 8'h0F, 4'b0000, "mul_after_rst");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add();
        test_alu_ops();
        test_mul();
        test_hold();
        test_back_to_back();
        test_mul_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
